// File: rtl/alu_mc_if.sv
// Request/response bundle between issue logic (master) and the multi-cycle ALU (slave).
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             ALU_valid_i;
  logic [3:0]       ALU_op_i;
  logic [WIDTH-1:0] ALU_data1_i;
  logic [WIDTH-1:0] ALU_data2_i;
  logic [WIDTH-1:0] ALU_result_o;
  logic             ALU_valid_o;
  logic             ALU_busy_o;

  modport master (
    output ALU_valid_i, ALU_op_i, ALU_data1_i, ALU_data2_i,
    input  ALU_result_o, ALU_valid_o, ALU_busy_o
  );

  modport slave (
    input  ALU_valid_i, ALU_op_i, ALU_data1_i, ALU_data2_i,
    output ALU_result_o, ALU_valid_o, ALU_busy_o
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/compare, iterative unsigned multiply and,
// when ALU_DIV_EN is defined, restoring unsigned divide/remainder.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave alu
);

  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_EQ    = 4'd3;
  localparam logic [3:0] OP_GEU   = 4'd4;
  localparam logic [3:0] OP_GES   = 4'd5;
  localparam logic [3:0] OP_MUL   = 4'd6;
  localparam logic [3:0] OP_MULHU = 4'd7;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'd8;
  localparam logic [3:0] OP_REMU  = 4'd9;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   prod_r;   // {partial product} or {remainder, quotient shifter}
  logic [WIDTH-1:0]     opnd_r;   // multiplicand or divisor
  logic                 sel_hi_r; // pick upper half of the final register (mulhu / remu)
  logic [WIDTH-1:0]     result_r;
  logic                 valid_r;
  logic                 busy_r;

  logic                 accept_s;
  logic                 last_s;
  logic [WIDTH-1:0]     single_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_nx_s;

  assign accept_s = alu.ALU_valid_i & ~busy_r;
  assign last_s   = (cnt_r == CNT_W'(WIDTH - 1));

  // Result of the single-cycle opcodes; reserved codes (and 8/9 without divider) give zero
  always_comb begin
    single_s = {WIDTH{1'b0}};
    case (alu.ALU_op_i)
      OP_ADD:  single_s = alu.ALU_data1_i + alu.ALU_data2_i;
      OP_SUB:  single_s = alu.ALU_data1_i - alu.ALU_data2_i;
      OP_EQ:   single_s = {{(WIDTH-1){1'b0}}, (alu.ALU_data1_i == alu.ALU_data2_i)};
      OP_GEU:  single_s = {{(WIDTH-1){1'b0}}, (alu.ALU_data1_i >= alu.ALU_data2_i)};
      OP_GES:  single_s = {{(WIDTH-1){1'b0}},
                           ($signed(alu.ALU_data1_i) >= $signed(alu.ALU_data2_i))};
      default: single_s = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add step: conditionally add multiplicand to upper half, then shift right
  always_comb begin
    if (prod_r[0]) begin
      mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    end else begin
      mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
    end
    mul_nx_s = {mul_sum_s, prod_r[WIDTH-1:1]};
  end

`ifdef ALU_DIV_EN
  logic [WIDTH+1:0]     div_trial_s;
  logic [2*WIDTH-1:0]   div_nx_s;

  // One restoring step; a zero divisor always "fits", giving all-ones quotient and remainder = dividend
  always_comb begin
    div_trial_s = {1'b0, prod_r[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_r};
    if (!div_trial_s[WIDTH+1]) begin
      div_nx_s = {div_trial_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b1};
    end else begin
      div_nx_s = {prod_r[2*WIDTH-2:0], 1'b0};
    end
  end
`endif

  // Control FSM with registered result/valid/busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      prod_r   <= {(2*WIDTH){1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      sel_hi_r <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_MUL: begin
          prod_r <= mul_nx_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (last_s) begin
            result_r <= sel_hi_r ? mul_nx_s[2*WIDTH-1:WIDTH] : mul_nx_s[WIDTH-1:0];
            valid_r  <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= ST_DONE;
          end else begin
            state_r  <= ST_MUL;
          end
        end
`ifdef ALU_DIV_EN
        ST_DIV: begin
          prod_r <= div_nx_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (last_s) begin
            result_r <= sel_hi_r ? div_nx_s[2*WIDTH-1:WIDTH] : div_nx_s[WIDTH-1:0];
            valid_r  <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= ST_DONE;
          end else begin
            state_r  <= ST_DIV;
          end
        end
`endif
        ST_IDLE, ST_DONE: begin
          cnt_r <= {CNT_W{1'b0}};
          if (accept_s) begin
            case (alu.ALU_op_i)
              OP_MUL, OP_MULHU: begin
                state_r  <= ST_MUL;
                busy_r   <= 1'b1;
                prod_r   <= {{WIDTH{1'b0}}, alu.ALU_data2_i};
                opnd_r   <= alu.ALU_data1_i;
                sel_hi_r <= (alu.ALU_op_i == OP_MULHU);
              end
`ifdef ALU_DIV_EN
              OP_DIVU, OP_REMU: begin
                state_r  <= ST_DIV;
                busy_r   <= 1'b1;
                prod_r   <= {{WIDTH{1'b0}}, alu.ALU_data1_i};
                opnd_r   <= alu.ALU_data2_i;
                sel_hi_r <= (alu.ALU_op_i == OP_REMU);
              end
`endif
              default: begin
                result_r <= single_s;
                valid_r  <= 1'b1;
                state_r  <= ST_IDLE;
              end
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign alu.ALU_result_o = result_r;
  assign alu.ALU_valid_o  = valid_r;
  assign alu.ALU_busy_o   = busy_r;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: randomized and directed operations against a
// plain-arithmetic reference model; honours ALU_DIV_EN like the design.
module tb_alu_mc;
  localparam int W = 32;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus ();
  alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .alu(bus));

  function automatic logic [W-1:0] ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = (2*W)'(a) * (2*W)'(b);
    case (op)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return W'(a == b);
      4'd4: return W'(a >= b);
      4'd5: return W'($signed(a) >= $signed(b));
      4'd6: return p[W-1:0];
      4'd7: return p[2*W-1:W];
      4'd8: return !DIV_EN ? '0 : (b == '0) ? '1 : a / b;
      4'd9: return !DIV_EN ? '0 : (b == '0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic bit is_multi(input logic [3:0] op);
    return (op == 4'd6) || (op == 4'd7) || (DIV_EN && (op == 4'd8 || op == 4'd9));
  endfunction

  // Present one request for exactly one edge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.ALU_valid_i = 1'b1;
    bus.ALU_op_i    = op;
    bus.ALU_data1_i = a;
    bus.ALU_data2_i = b;
    @(negedge clk);
    bus.ALU_valid_i = 1'b0;
  endtask

  // Watch negedges until a valid pulse (bounded); obs = negedges seen, 1 = first after accept.
  task automatic collect(output logic [W-1:0] res, output int obs, output int busy_cnt,
                         output bit got);
    obs = 1;
    busy_cnt = 0;
    while (!bus.ALU_valid_o && obs < W + 8) begin
      if (bus.ALU_busy_o) busy_cnt++;
      @(negedge clk);
      obs++;
    end
    got = bus.ALU_valid_o;
    res = bus.ALU_result_o;
  endtask

  task automatic test_reset();
    logic [W-1:0] res;
    int obs, bc;
    bit got;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.ALU_result_o !== '0) begin n_err++; $display("FAIL reset_result got=%h exp=0", bus.ALU_result_o); end
    n_vec++; if (bus.ALU_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.ALU_valid_o); end
    n_vec++; if (bus.ALU_busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.ALU_busy_o); end
    rst_n = 1'b1;
    issue(4'd1, 32'd5, 32'd7);
    collect(res, obs, bc, got);
    n_vec++; if (!got || res !== 32'd12 || obs != 1) begin n_err++; $display("FAIL add_after_reset got=%h obs=%0d valid=%b exp=0000000c obs=1", res, obs, got); end
    @(negedge clk);
    n_vec++; if (bus.ALU_valid_o !== 1'b0) begin n_err++; $display("FAIL add_pulse_width valid=%b exp=0", bus.ALU_valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   op_q[$];
    logic [W-1:0] a_q[$];
    logic [W-1:0] b_q[$];
    logic [3:0]   op;
    logic [W-1:0] exp;
    int n;
    op_q = '{4'd2, 4'd5, 4'd4, 4'd3};
    a_q  = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9};
    b_q  = '{32'd5, 32'd1, 32'd1, 32'd9};
    for (int i = 0; i < 16; i++) begin
      do op = 4'($urandom_range(0, 15)); while (is_multi(op));
      op_q.push_back(op);
      a_q.push_back($urandom);
      b_q.push_back(($urandom_range(0, 3) == 0) ? a_q[$] : W'($urandom));
    end
    n = op_q.size();
    @(negedge clk);
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        exp = ref_model(op_q[i-1], a_q[i-1], b_q[i-1]);
        n_vec++;
        if (bus.ALU_valid_o !== 1'b1 || bus.ALU_busy_o !== 1'b0 || bus.ALU_result_o !== exp) begin
          n_err++;
          $display("FAIL b2b_%0d op=%0d a=%h b=%h got=%h valid=%b busy=%b exp=%h", i-1, op_q[i-1],
                   a_q[i-1], b_q[i-1], bus.ALU_result_o, bus.ALU_valid_o, bus.ALU_busy_o, exp);
        end
      end
      if (i < n) begin
        bus.ALU_valid_i = 1'b1;
        bus.ALU_op_i    = op_q[i];
        bus.ALU_data1_i = a_q[i];
        bus.ALU_data2_i = b_q[i];
      end else begin
        bus.ALU_valid_i = 1'b0;
      end
      @(negedge clk);
    end
    n_vec++; if (bus.ALU_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_tail valid=%b exp=0", bus.ALU_valid_o); end
  endtask

  // Shared body for mul/div scenarios: latency, busy length, result and single-cycle pulse.
  task automatic run_multi(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    logic [W-1:0] res, exp;
    int obs, bc;
    bit got;
    exp = ref_model(op, a, b);
    issue(op, a, b);
    collect(res, obs, bc, got);
    n_vec++; if (!got || res !== exp) begin n_err++; $display("FAIL %s_result op=%0d a=%h b=%h got=%h valid=%b exp=%h", tag, op, a, b, res, got, exp); end
    n_vec++; if (obs != W + 1 || bc != W) begin n_err++; $display("FAIL %s_timing op=%0d obs=%0d busy=%0d exp obs=%0d busy=%0d", tag, op, obs, bc, W + 1, W); end
    @(negedge clk);
    n_vec++; if (bus.ALU_valid_o !== 1'b0 || bus.ALU_result_o !== exp) begin n_err++; $display("FAIL %s_hold valid=%b res=%h exp valid=0 res=%h", tag, bus.ALU_valid_o, bus.ALU_result_o, exp); end
  endtask

  task automatic test_mul();
    run_multi("mul", 4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_multi("mulhu", 4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 4; i++) begin
      run_multi("mul_rnd", (i % 2 == 0) ? 4'd6 : 4'd7, W'($urandom), W'($urandom));
    end
  endtask

  task automatic test_div();
`ifdef ALU_DIV_EN
    run_multi("divu", 4'd8, 32'd100, 32'd7);
    run_multi("remu", 4'd9, 32'd100, 32'd7);
    run_multi("divu0", 4'd8, 32'hDEADBEEF, 32'd0);
    run_multi("remu0", 4'd9, 32'd37, 32'd0);
    for (int i = 0; i < 4; i++) begin
      run_multi("div_rnd", (i % 2 == 0) ? 4'd8 : 4'd9, W'($urandom),
                (i < 2) ? W'($urandom_range(1, 300)) : W'($urandom));
    end
`else
    logic [W-1:0] res;
    int obs, bc;
    bit got;
    issue(4'd8, 32'd100, 32'd7);
    collect(res, obs, bc, got);
    n_vec++; if (!got || res !== '0 || obs != 1 || bc != 0) begin n_err++; $display("FAIL divu_disabled got=%h obs=%0d busy=%0d exp=0 obs=1 busy=0", res, obs, bc); end
`endif
  endtask

  task automatic test_busy_request();
    logic [W-1:0] exp;
    int obs;
    exp = ref_model(4'd6, 32'h12345678, 32'h9ABCDEF0);
    @(negedge clk);
    bus.ALU_valid_i = 1'b1;
    bus.ALU_op_i    = 4'd6;
    bus.ALU_data1_i = 32'h12345678;
    bus.ALU_data2_i = 32'h9ABCDEF0;
    @(negedge clk);
    bus.ALU_op_i    = 4'd1;
    bus.ALU_data1_i = 32'd1;
    bus.ALU_data2_i = 32'd1;
    obs = 1;
    while (!bus.ALU_valid_o && obs < W + 8) begin
      @(negedge clk);
      obs++;
    end
    n_vec++; if (bus.ALU_valid_o !== 1'b1 || bus.ALU_result_o !== exp || obs != W + 1) begin n_err++; $display("FAIL busy_req_mul got=%h obs=%0d exp=%h obs=%0d", bus.ALU_result_o, obs, exp, W + 1); end
    @(negedge clk);
    bus.ALU_valid_i = 1'b0;
    n_vec++; if (bus.ALU_valid_o !== 1'b1 || bus.ALU_result_o !== 32'd2 || bus.ALU_busy_o !== 1'b0) begin n_err++; $display("FAIL busy_req_add got=%h valid=%b busy=%b exp=00000002 valid=1 busy=0", bus.ALU_result_o, bus.ALU_valid_o, bus.ALU_busy_o); end
    @(negedge clk);
    n_vec++; if (bus.ALU_valid_o !== 1'b0) begin n_err++; $display("FAIL busy_req_tail valid=%b exp=0", bus.ALU_valid_o); end
  endtask

  task automatic test_reset_mid();
    bit saw_valid;
    issue(4'd6, 32'd1234, 32'd5678);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.ALU_busy_o !== 1'b0 || bus.ALU_result_o !== '0 || bus.ALU_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_mid busy=%b res=%h valid=%b exp 0/0/0", bus.ALU_busy_o, bus.ALU_result_o, bus.ALU_valid_o); end
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (bus.ALU_valid_o !== 1'b0) saw_valid = 1'b1;
    end
    n_vec++; if (saw_valid) begin n_err++; $display("FAIL reset_mid_no_pulse saw_valid=1 exp=0"); end
  endtask

  initial begin
    bus.ALU_valid_i = 1'b0;
    bus.ALU_op_i    = 4'd0;
    bus.ALU_data1_i = '0;
    bus.ALU_data2_i = '0;
    test_reset();
    test_back_to_back();
    test_mul();
    test_div();
    test_busy_request();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
